// File: rtl/sam_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : sam_tx_if                                                       |
// | Purpose   : Host-side and line-side signal bundle of the SAM transmitter.   |
// |             master = host / stimulus end, slave = the transmitter itself.   |
// | Signals   : cfg_start  1-cycle request to send a configuration frame        |
// |             n_in       length exponent, L = 1 << n_in                       |
// |             d_in       key word d                                           |
// |             cn_in      mask word N                                          |
// |             msg_start  1-cycle request to send a message                    |
// |             msg_in     message word                                         |
// |             mode       high during the configuration frame                  |
// |             str        serial line towards the SAM encoder                  |
// |             ready      transmitter accepts a new request                    |
// |             done       1-cycle pulse at the end of a frame or message       |
// |             err        1-cycle pulse for a rejected configuration request   |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sam_tx_if #(
  parameter int LOG2W = 4
);
  localparam int C_MAXW = 1 << LOG2W;

  logic              cfg_start;
  logic [3:0]        n_in;
  logic [C_MAXW-1:0] d_in;
  logic [C_MAXW-1:0] cn_in;
  logic              msg_start;
  logic [C_MAXW-1:0] msg_in;
  logic              mode;
  logic              str;
  logic              ready;
  logic              done;
  logic              err;

  modport master (
    output cfg_start, n_in, d_in, cn_in, msg_start, msg_in,
    input  mode, str, ready, done, err
  );

  modport slave (
    input  cfg_start, n_in, d_in, cn_in, msg_start, msg_in,
    output mode, str, ready, done, err
  );
endinterface
`default_nettype wire

// File: rtl/sam_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : sam_tx                                                          |
// | Purpose   : Serial transmitter for the SAM link. Sends a configuration      |
// |             frame (n, key d, mask N) with mode high, then sends message     |
// |             bits as pulse-width-coded symbols on str, MSB first.            |
// | Ports     : clk    clock, all logic on its rising edge                      |
// |             reset  asynchronous, active-high reset                          |
// |             bus    sam_tx_if.slave (host requests in, mode/str/status out)  |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sam_tx #(
  parameter int LOG2W   = 4,
  parameter int T_LONG  = 12,
  parameter int T_SHORT = 6,
  parameter int T_GUARD = 2
) (
  input  logic     clk,
  input  logic     reset,
  sam_tx_if.slave  bus
);

  localparam int C_MAXW  = 1 << LOG2W;
  localparam int C_BW    = LOG2W + 1;
  // The cycle counter must hold the longest timed phase: a symbol half,
  // the guard, the four n bits or a whole L-bit mask field.
  localparam int C_CMAX0 = (T_LONG > T_SHORT) ? T_LONG : T_SHORT;
  localparam int C_CMAX1 = (C_CMAX0 > T_GUARD) ? C_CMAX0 : T_GUARD;
  localparam int C_CMAX2 = (C_CMAX1 > 4) ? C_CMAX1 : 4;
  localparam int C_CMAX  = (C_CMAX2 > C_MAXW) ? C_CMAX2 : C_MAXW;
  localparam int C_CW    = $clog2(C_CMAX + 1);

  typedef logic [C_CW-1:0]  cnt_t;
  typedef logic [C_BW-1:0]  bit_t;
  typedef logic [LOG2W-1:0] idx_t;
  typedef logic [1:0]       nsel_t;

  localparam cnt_t       C_CNT_ONE = cnt_t'(1);
  localparam cnt_t       C_TL      = cnt_t'(T_LONG);
  localparam cnt_t       C_TS      = cnt_t'(T_SHORT);
  localparam cnt_t       C_TG      = cnt_t'(T_GUARD);
  localparam cnt_t       C_NBITS   = cnt_t'(4);
  localparam bit_t       C_BIT_ONE = bit_t'(1);
  localparam bit_t       C_BIT_TWO = bit_t'(2);
  localparam logic [3:0] C_NMAX    = 4'(LOG2W);

  // Parameter sanity: the receiver discriminates symbols by their period,
  // and zero-length phases would break the countdown scheme.
  generate
    if ((T_LONG + T_SHORT) < 10 || (T_LONG + T_SHORT) > 60) begin : g_bad_period
      $error("sam_tx: symbol period T_LONG+T_SHORT must lie in 10..60");
    end
    if (T_SHORT < 1 || T_LONG < 1 || T_GUARD < 1) begin : g_bad_timing
      $error("sam_tx: T_LONG, T_SHORT and T_GUARD must be at least 1");
    end
    if (LOG2W < 1 || LOG2W > 15) begin : g_bad_width
      $error("sam_tx: LOG2W must lie in 1..15");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PRE   = 4'd1,
    S_CFG_N = 4'd2,
    S_CFG_D = 4'd3,
    S_CFG_C = 4'd4,
    S_GUARD = 4'd5,
    S_RDY   = 4'd6,
    S_HI    = 4'd7,
    S_LO    = 4'd8,
    S_MARK  = 4'd9
  } state_t;

  state_t            r_state, w_state_nxt;
  cnt_t              r_cnt,   w_cnt_nxt;    // cycles left in the current phase
  bit_t              r_bit,   w_bit_nxt;    // bits left in d field / message, L..1
  logic [3:0]        r_n,     w_n_nxt;
  logic [C_MAXW-1:0] r_d,     w_d_nxt;
  logic [C_MAXW-1:0] r_cn,    w_cn_nxt;
  logic [C_MAXW-1:0] r_msg,   w_msg_nxt;

  logic r_mode,  w_mode_nxt;
  logic r_str,   w_str_nxt;
  logic r_ready, w_ready_nxt;
  logic r_done,  w_done_nxt;
  logic r_err,   w_err_nxt;

  bit_t w_len;
  logic w_req_ok;
  logic w_first_bit;
  logic w_cur_bit;
  logic w_following_bit;

  // L from the latched exponent; r_n never exceeds LOG2W so L fits C_BW bits.
  assign w_len           = C_BIT_ONE << r_n;
  assign w_req_ok        = (bus.n_in <= C_NMAX);
  // Message bit values needed when loading a symbol's first half:
  // MSB of the word being latched, the bit now on the line, and the next one.
  assign w_first_bit     = bus.msg_in[idx_t'(w_len - C_BIT_ONE)];
  assign w_cur_bit       = r_msg[idx_t'(r_bit - C_BIT_ONE)];
  assign w_following_bit = r_msg[idx_t'(r_bit - C_BIT_TWO)];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_n     <= '0;
      r_d     <= '0;
      r_cn    <= '0;
      r_msg   <= '0;
      r_mode  <= 1'b0;
      r_str   <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_n     <= w_n_nxt;
      r_d     <= w_d_nxt;
      r_cn    <= w_cn_nxt;
      r_msg   <= w_msg_nxt;
      r_mode  <= w_mode_nxt;
      r_str   <= w_str_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state plus the output values that state will present. Outputs are
  // derived from the next-cycle state so that they leave the flops aligned
  // with the state they describe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_n_nxt     = r_n;
    w_d_nxt     = r_d;
    w_cn_nxt    = r_cn;
    w_msg_nxt   = r_msg;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE, S_RDY: begin
        if (bus.cfg_start) begin
          // Configuration wins over a simultaneous message request.
          if (w_req_ok) begin
            w_n_nxt     = bus.n_in;
            w_d_nxt     = bus.d_in;
            w_cn_nxt    = bus.cn_in;
            w_cnt_nxt   = '0;
            w_state_nxt = S_PRE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (bus.msg_start && (r_state == S_RDY)) begin
          w_msg_nxt   = bus.msg_in;
          w_bit_nxt   = w_len;
          w_cnt_nxt   = w_first_bit ? C_TL : C_TS;
          w_state_nxt = S_HI;
        end
      end

      S_PRE: begin
        w_cnt_nxt   = C_NBITS;
        w_bit_nxt   = w_len;
        w_state_nxt = S_CFG_N;
      end

      S_CFG_N: begin
        if (r_cnt == C_CNT_ONE) begin
          w_state_nxt = S_CFG_D;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end

      S_CFG_D: begin
        if (r_bit == C_BIT_ONE) begin
          // The mask field is timed by the cycle counter so the bit counter
          // is only ever reloaded on leaving PRE or RDY.
          w_cnt_nxt   = cnt_t'(w_len);
          w_state_nxt = S_CFG_C;
        end else begin
          w_bit_nxt = r_bit - C_BIT_ONE;
        end
      end

      S_CFG_C: begin
        if (r_cnt == C_CNT_ONE) begin
          w_cnt_nxt   = C_TG;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_GUARD;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end

      S_GUARD: begin
        if (r_cnt == C_CNT_ONE) begin
          w_state_nxt = S_RDY;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end

      S_HI: begin
        if (r_cnt == C_CNT_ONE) begin
          w_cnt_nxt   = w_cur_bit ? C_TS : C_TL;
          w_state_nxt = S_LO;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end

      S_LO: begin
        if (r_cnt == C_CNT_ONE) begin
          if (r_bit == C_BIT_ONE) begin
            w_state_nxt = S_MARK;
          end else begin
            w_bit_nxt   = r_bit - C_BIT_ONE;
            w_cnt_nxt   = w_following_bit ? C_TL : C_TS;
            w_state_nxt = S_HI;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end

      S_MARK: begin
        // The closing rising edge lets the receiver measure the last low phase.
        w_cnt_nxt   = C_TG;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_GUARD;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_mode_nxt  = (w_state_nxt inside {S_PRE, S_CFG_N, S_CFG_D, S_CFG_C});
    w_ready_nxt = (w_state_nxt inside {S_IDLE, S_RDY});

    case (w_state_nxt)
      S_CFG_N: w_str_nxt = w_n_nxt[nsel_t'(w_cnt_nxt - C_CNT_ONE)];
      S_CFG_D: w_str_nxt = w_d_nxt[idx_t'(w_bit_nxt - C_BIT_ONE)];
      S_CFG_C: w_str_nxt = w_cn_nxt[idx_t'(w_cnt_nxt - C_CNT_ONE)];
      S_HI:    w_str_nxt = 1'b1;
      S_MARK:  w_str_nxt = 1'b1;
      default: w_str_nxt = 1'b0;
    endcase
  end

  assign bus.mode  = r_mode;
  assign bus.str   = r_str;
  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sam_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_sam_tx                                                       |
// | Purpose   : Self-checking bench for sam_tx. A queue-based model expands     |
// |             every accepted request into its expected per-cycle line         |
// |             waveform; directed cases plus random traffic are compared       |
// |             against it every cycle.                                         |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sam_tx;
  localparam int LOG2W   = 4;
  localparam int MAXW    = 1 << LOG2W;
  localparam int T_LONG  = 12;
  localparam int T_SHORT = 6;
  localparam int T_GUARD = 2;

  // Expected output record: {mode, str, ready, done, err}
  localparam logic [4:0] E_IDLE = 5'b00100;
  localparam logic [4:0] E_ERR  = 5'b00101;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sam_tx_if #(.LOG2W(LOG2W)) bus ();

  sam_tx #(
    .LOG2W   (LOG2W),
    .T_LONG  (T_LONG),
    .T_SHORT (T_SHORT),
    .T_GUARD (T_GUARD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic       chk_en = 1'b0;
  logic [4:0] q[$];
  logic [4:0] cur    = E_IDLE;
  logic       cfg_ok = 1'b0;
  logic [3:0] m_n    = 4'd0;

  function automatic logic [4:0] rec(logic mode, logic str, logic ready, logic done, logic err);
    return {mode, str, ready, done, err};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_guard();
    for (int g = 0; g < T_GUARD; g++) q.push_back(rec(1'b0, 1'b0, 1'b0, (g == 0), 1'b0));
  endtask

  // Configuration frame: PRE, n[3..0], d[L-1..0], N[L-1..0], then guard.
  task automatic push_cfg(logic [3:0] n, logic [MAXW-1:0] d, logic [MAXW-1:0] cn);
    int len;
    len = 1 << n;
    q.push_back(rec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 3; i >= 0; i--)      q.push_back(rec(1'b1, n[i],  1'b0, 1'b0, 1'b0));
    for (int i = len - 1; i >= 0; i--) q.push_back(rec(1'b1, d[i],  1'b0, 1'b0, 1'b0));
    for (int i = len - 1; i >= 0; i--) q.push_back(rec(1'b1, cn[i], 1'b0, 1'b0, 1'b0));
    push_guard();
  endtask

  // Message: one symbol of period T_LONG+T_SHORT per bit, high part long for '1'.
  task automatic push_msg(logic [MAXW-1:0] m, logic [3:0] n);
    int len;
    int hi;
    len = 1 << n;
    for (int b = len - 1; b >= 0; b--) begin
      hi = m[b] ? T_LONG : T_SHORT;
      for (int k = 0; k < T_LONG + T_SHORT; k++) q.push_back(rec(1'b0, (k < hi), 1'b0, 1'b0, 1'b0));
    end
    q.push_back(rec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    push_guard();
  endtask

  // Reference model: decides what the outputs show after each edge.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      cur    = E_IDLE;
      cfg_ok = 1'b0;
    end else if (!cur[2]) begin
      cur = (q.size() > 0) ? q.pop_front() : E_IDLE;
    end else if (bus.cfg_start) begin
      if (bus.n_in > 4'(LOG2W)) begin
        cur = E_ERR;
      end else begin
        m_n    = bus.n_in;
        cfg_ok = 1'b1;
        push_cfg(bus.n_in, bus.d_in, bus.cn_in);
        cur = q.pop_front();
      end
    end else if (bus.msg_start && cfg_ok) begin
      push_msg(bus.msg_in, m_n);
      cur = q.pop_front();
    end else begin
      cur = E_IDLE;
    end
  end

  // Cycle compare, away from the active edge.
  initial forever begin
    logic [4:0] act;
    @(negedge clk);
    if (chk_en) begin
      act = {bus.mode, bus.str, bus.ready, bus.done, bus.err};
      n_chk++;
      if (act !== cur) begin
        n_fail++;
        $display("FAIL cycle_compare at %0t: got mode/str/ready/done/err=%b expected %b", $time, act, cur);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(int bound);
    int k;
    k = 0;
    while (!bus.ready && k < bound) begin
      tick();
      k++;
    end
    check("wait_ready", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int         cnt;
    int         flags;
    logic [12:0] bits;
    logic       s[$];
    int         runs[$];
    int         r;
    logic [3:0] dec;

    bus.cfg_start = 1'b0;
    bus.msg_start = 1'b0;
    bus.n_in      = 4'd0;
    bus.d_in      = '0;
    bus.cn_in     = '0;
    bus.msg_in    = '0;

    // Reset held, then released; idle for 20 cycles.
    repeat (3) tick();
    chk_en = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset_mode",  32'(bus.mode),  32'd0);
    check("reset_str",   32'(bus.str),   32'd0);
    check("reset_ready", 32'(bus.ready), 32'd1);
    flags = 0;
    for (int i = 0; i < 20; i++) begin
      flags += int'(bus.done) + int'(bus.err);
      tick();
    end
    check("idle_done_err", 32'(flags), 32'd0);

    // msg_start before any configuration is ignored.
    bus.msg_start = 1'b1; bus.msg_in = 16'hFFFF;
    tick();
    bus.msg_start = 1'b0;
    check("msg_unconfigured_ready", 32'(bus.ready), 32'd1);

    // Configuration n=2, d=1010, N=0001; upper word bits must not appear.
    bus.cfg_start = 1'b1; bus.n_in = 4'd2; bus.d_in = 16'hF0FA; bus.cn_in = 16'h7771;
    tick();
    bus.cfg_start = 1'b0;
    cnt  = 0;
    bits = '0;
    while (bus.mode && cnt < 40) begin
      bits = {bits[11:0], bus.str};
      cnt++;
      tick();
    end
    check("cfg_mode_cycles", 32'(cnt), 32'd13);
    check("cfg_str_bits", 32'(bits), 32'(13'b0_0010_1010_0001));
    check("cfg_done", 32'(bus.done), 32'd1);
    wait_ready(20);

    // Message 1100 with a msg_start and a cfg_start injected while busy.
    bus.msg_in = 16'h123C; bus.msg_start = 1'b1;
    tick();
    bus.msg_start = 1'b0;
    cnt = 0;
    while (!bus.ready && cnt < 400) begin
      s.push_back(bus.str);
      bus.msg_start = (cnt == 10);
      bus.cfg_start = (cnt == 20);
      bus.n_in      = 4'd1;
      tick();
      cnt++;
    end
    bus.msg_start = 1'b0;
    bus.cfg_start = 1'b0;
    // L*(T_LONG+T_SHORT) + MARK + T_GUARD = 4*18 + 1 + 2
    check("msg_duration", 32'(cnt), 32'd75);
    r = 0;
    foreach (s[i]) begin
      if (s[i]) r++;
      else if (r > 0) begin runs.push_back(r); r = 0; end
    end
    if (r > 0) runs.push_back(r);
    check("msg_high_runs", 32'(runs.size()), 32'd5);
    dec = '0;
    if (runs.size() >= 4)
      for (int i = 0; i < 4; i++) dec = {dec[2:0], (runs[i] > (T_LONG + T_SHORT) / 2)};
    check("msg_decoded", 32'(dec), 32'(4'b1100));
    check("encoder_msgcd", 32'((dec ^ 4'b1010) | 4'b0001), 32'(4'b0111));

    // Illegal exponent: err pulse, nothing else changes.
    bus.cfg_start = 1'b1; bus.n_in = 4'd5;
    tick();
    bus.cfg_start = 1'b0;
    check("err_pulse", 32'(bus.err),   32'd1);
    check("err_mode",  32'(bus.mode),  32'd0);
    check("err_ready", 32'(bus.ready), 32'd1);
    tick();
    check("err_clears", 32'(bus.err), 32'd0);

    // cfg_start and msg_start together in RDY: configuration is taken.
    bus.cfg_start = 1'b1; bus.msg_start = 1'b1; bus.n_in = 4'd1;
    bus.d_in = 16'h0002; bus.cn_in = 16'h0001;
    tick();
    bus.cfg_start = 1'b0; bus.msg_start = 1'b0;
    check("both_start_mode", 32'(bus.mode), 32'd1);
    wait_ready(40);

    // Asynchronous reset in the middle of the key field.
    bus.cfg_start = 1'b1; bus.n_in = 4'd4; bus.d_in = 16'hFFFF; bus.cn_in = 16'h0000;
    tick();
    bus.cfg_start = 1'b0;
    repeat (7) tick();
    check("midframe_mode", 32'(bus.mode), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_mode",  32'(bus.mode),  32'd0);
    check("async_reset_str",   32'(bus.str),   32'd0);
    check("async_reset_ready", 32'(bus.ready), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Shortest frame, n=0: PRE + 4 n bits + d[0] + N[0].
    bus.cfg_start = 1'b1; bus.n_in = 4'd0; bus.d_in = 16'h0001; bus.cn_in = 16'h0000;
    tick();
    bus.cfg_start = 1'b0;
    cnt = 0;
    while (bus.mode && cnt < 40) begin
      cnt++;
      tick();
    end
    check("n0_mode_cycles", 32'(cnt), 32'd7);
    wait_ready(20);

    // Random traffic, including requests while busy and occasional resets.
    for (int c = 0; c < 8000; c++) begin
      bus.cfg_start = ($urandom_range(0, 99) < 2);
      bus.msg_start = ($urandom_range(0, 99) < 6);
      bus.n_in      = 4'($urandom_range(0, 5));
      bus.d_in      = 16'($urandom);
      bus.cn_in     = 16'($urandom);
      bus.msg_in    = 16'($urandom);
      reset         = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset         = 1'b0;
    bus.cfg_start = 1'b0;
    bus.msg_start = 1'b0;
    repeat (400) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
